instr_decode_queue: RTL and testbench

- Buffers fetched instructions between the fetch stage and the decode stage.
- Drives the decode stage, which includes the immediate generator. For the head entry it presents the instruction word, its PC and the decoded 3-bit ExtOp.
- Decouples fetch and decode with valid/ready handshakes on both sides.
- Supports a single-cycle flush for branch/jump redirects.

---
 rtl/instr_decode_queue.sv | 144 ++++++++++++++
 tb/tb_instr_decode_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_queue.sv
// -----------------------------------------------------------------------------
// instr_decode_queue
//
// Circular instruction buffer between the fetch stage and the decode stage.
// Fetch pushes {pc, instr} pairs through a valid/ready handshake. Decode
// consumes the head entry through a second valid/ready handshake. For the
// head entry, the queue presents the PC, the instruction word and the
// immediate format (ExtOp). It also raises an unsupported-opcode flag.
// A single-cycle flush empties the queue on a branch or jump redirect.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears pointers and count)
//   in_valid   fetch presents an instruction
//   in_ready   queue can accept this cycle (count != DEPTH)
//   in_pc      PC of the incoming instruction
//   in_instr   incoming instruction word
//   out_valid  head entry is valid (count != 0)
//   out_ready  decode consumes the head this cycle
//   out_pc     head PC
//   out_instr  head instruction
//   ExtOp      head immediate format: 000 I, 001 U, 010 S, 011 B, 100 J
//   illegal    head opcode is unsupported
//   flush      discard all entries at the next edge
//   count      current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module instr_decode_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic [2:0]    ExtOp,
  output logic          illegal,
  input  logic          flush,
  output logic [AW:0]   count
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  // Immediate format codes
  localparam logic [2:0] LP_EXT_I = 3'b000;
  localparam logic [2:0] LP_EXT_U = 3'b001;
  localparam logic [2:0] LP_EXT_S = 3'b010;
  localparam logic [2:0] LP_EXT_B = 3'b011;
  localparam logic [2:0] LP_EXT_J = 3'b100;

  // Supported major opcodes
  localparam logic [6:0] LP_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] LP_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] LP_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] LP_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] LP_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] LP_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] LP_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] LP_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] LP_OPC_OP     = 7'b0110011;
  localparam logic [6:0] LP_OPC_SYSTEM = 7'b1110011;

  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  logic          w_push;
  logic          w_pop;
  logic [6:0]    w_opcode;

  // in_ready depends on the registered count only, so no combinational
  // path exists from out_ready back to fetch.
  assign in_ready  = (r_count != LP_FULL);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // NOTE: storage arrays have no reset. The pointers alone define which
  // entries are live, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_pc_mem[r_wr_ptr]    <= in_pc;
      r_instr_mem[r_wr_ptr] <= in_instr;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments, so every
  // right-hand side samples the pre-edge value of the pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      // The redirect overrides any push or pop in the same cycle.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow wraps.
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_pc    = r_pc_mem[r_rd_ptr];
  assign out_instr = r_instr_mem[r_rd_ptr];
  assign w_opcode  = out_instr[6:0];

  // NOTE: both outputs get defaults before the case, so no path through
  // this block leaves them unassigned. This prevents latch inference.
  always_comb begin
    ExtOp   = LP_EXT_I;
    illegal = 1'b0;
    case (w_opcode)
      LP_OPC_LUI,
      LP_OPC_AUIPC:  ExtOp = LP_EXT_U;
      LP_OPC_JAL:    ExtOp = LP_EXT_J;
      LP_OPC_BRANCH: ExtOp = LP_EXT_B;
      LP_OPC_STORE:  ExtOp = LP_EXT_S;
      LP_OPC_JALR,
      LP_OPC_LOAD,
      LP_OPC_OPIMM,
      LP_OPC_OP,
      LP_OPC_SYSTEM: ExtOp = LP_EXT_I;
      default:       illegal = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_instr_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_queue
//
// Directed testbench for instr_decode_queue. Each accepted push places the
// expected {pc, instr, ExtOp, illegal} on a scoreboard queue. The head and
// occupancy are compared against that queue on every falling edge.
// -----------------------------------------------------------------------------
module tb_instr_decode_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  ext;
    logic        ill;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  ExtOp;
  logic        illegal;
  logic        flush;
  logic [2:0]  count;

  ent_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  instr_decode_queue #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .ExtOp     (ExtOp),
    .illegal   (illegal),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus. Check outputs at the falling edge, then
  // update the scoreboard at the rising edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [2:0] ext, input logic ill,
                      input logic rdy, input logic fl);
    logic exp_push;
    logic exp_pop;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    check("count",     32'(count),     32'(sb.size()));
    check("in_ready",  32'(in_ready),  32'(sb.size() != 4));
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_pc",    out_pc,           sb[0].pc);
      check("out_instr", out_instr,        sb[0].instr);
      check("ExtOp",     32'(ExtOp),       32'(sb[0].ext));
      check("illegal",   32'(illegal),     32'(sb[0].ill));
    end
    exp_push = v && (sb.size() != 4);
    exp_pop  = rdy && (sb.size() != 0);
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (exp_pop)  void'(sb.pop_front());
      if (exp_push) sb.push_back('{pc: pc, instr: instr, ext: ext, ill: ill});
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_count",     32'(count),     32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // A single addi becomes visible one cycle after its push
    step(1'b1, 32'h0, 32'h00500093, 3'b000, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("addi_count", 32'(count), 32'd1);
    idle(1'b1);
    idle(1'b0);

    // Fill the queue, reject a fifth push, then drain in FIFO order
    step(1'b1, 32'h100, 32'h00000097, 3'b001, 1'b0, 1'b0, 1'b0); // auipc
    step(1'b1, 32'h104, 32'h000080e7, 3'b000, 1'b0, 1'b0, 1'b0); // jalr
    step(1'b1, 32'h108, 32'h0000a103, 3'b000, 1'b0, 1'b0, 1'b0); // lw
    step(1'b1, 32'h10c, 32'h00000073, 3'b000, 1'b0, 1'b0, 1'b0); // ecall
    step(1'b1, 32'h110, 32'h00100113, 3'b000, 1'b0, 1'b0, 1'b0); // refused
    check("full_count",    32'(count),    32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    check("drained_count", 32'(count), 32'd0);

    // Continuous push and pop through the pipeline
    step(1'b1, 32'h200, 32'h123450b7, 3'b001, 1'b0, 1'b1, 1'b0); // lui
    step(1'b1, 32'h204, 32'h00112023, 3'b010, 1'b0, 1'b1, 1'b0); // sw
    check("stream_count_a", 32'(count), 32'd1);
    step(1'b1, 32'h208, 32'h00000463, 3'b011, 1'b0, 1'b1, 1'b0); // beq
    step(1'b1, 32'h20c, 32'h008000ef, 3'b100, 1'b0, 1'b1, 1'b0); // jal
    check("stream_count_b", 32'(count), 32'd1);
    idle(1'b1);
    idle(1'b0);

    // Flush while full with a simultaneous push attempt
    step(1'b1, 32'h300, 32'h002081b3, 3'b000, 1'b0, 1'b0, 1'b0); // add (OP)
    step(1'b1, 32'h304, 32'h00500093, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h308, 32'h00112023, 3'b010, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h30c, 32'h00000463, 3'b011, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h310, 32'h123450b7, 3'b001, 1'b0, 1'b1, 1'b1);
    check("flush_count",     32'(count),     32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    idle(1'b0);

    // Flush mid-stream with a push that an unflushed queue would accept
    step(1'b1, 32'h400, 32'h00000097, 3'b001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h404, 32'h008000ef, 3'b100, 1'b0, 1'b1, 1'b1);
    idle(1'b0);
    step(1'b1, 32'h500, 32'h00112023, 3'b010, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // An unsupported opcode is flagged but otherwise handled normally
    step(1'b1, 32'h600, 32'h0000000f, 3'b000, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    check("illegal_flag", 32'(illegal), 32'd1);
    idle(1'b1);
    check("illegal_popped_count", 32'(count), 32'd0);

    // Asynchronous reset mid-stream after three pushes
    step(1'b1, 32'h700, 32'h00500093, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h704, 32'h00000097, 3'b001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h708, 32'h000080e7, 3'b000, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_count",     32'(count),     32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd1);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(1'b0);
    step(1'b1, 32'h800, 32'h00000463, 3'b011, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
